// File: rtl/microwave_sequencer_if.sv
// Front-panel bundle between the microwave sequencer and its surroundings:
// debounced keypad/buttons, door switch and tick in; magnetron, beeper, display and state out.
interface microwave_sequencer_if;
    logic       tick_1hz;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic       mag_on;
    logic       beep;
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic [2:0] state_o;

    modport master (
        output tick_1hz, key_valid, key_digit, startn, stopn, clearn, door_closed,
        input  mag_on, beep, min_t, min_u, sec_t, sec_u, state_o
    );

    modport slave (
        input  tick_1hz, key_valid, key_digit, startn, stopn, clearn, door_closed,
        output mag_on, beep, min_t, min_u, sec_t, sec_u, state_o
    );
endinterface

// File: rtl/microwave_sequencer.sv
// Cooking sequencer: BCD MM:SS entry, 1 Hz countdown, door interlock on the magnetron
// and an end-of-cycle beeper. State is exported on state_o for debug and LEDs.
module microwave_sequencer #(
    parameter int QUICK_SEC  = 30,
    parameter int BEEP_TICKS = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    microwave_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_COOKING = 3'd2,
        S_PAUSED  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [3:0] QUICK_T  = 4'(QUICK_SEC / 10);
    localparam logic [3:0] QUICK_U  = 4'(QUICK_SEC % 10);
    localparam logic [3:0] BEEP_END = 4'(BEEP_TICKS - 1);

    state_t     state_q;
    logic [3:0] min_t_q, min_u_q, sec_t_q, sec_u_q;
    logic [3:0] beep_cnt_q;
    logic       beep_q;
    logic       start_prev_q, stop_prev_q, clear_prev_q;
    logic       start_ev_q, stop_ev_q, clear_ev_q;

    logic        key_ok;
    logic        time_zero;
    logic        at_one;
    logic [15:0] time_dec;

    // Plain BCD borrow chain; seconds tens wraps to 5, everything else to 9.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = t;
        if (su != 4'd0) su = su - 4'd1;
        else begin
            su = 4'd9;
            if (st != 4'd0) st = st - 4'd1;
            else begin
                st = 4'd5;
                if (mu != 4'd0) mu = mu - 4'd1;
                else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    assign key_ok    = bus.key_valid && (bus.key_digit <= 4'd9);
    assign time_zero = ({min_t_q, min_u_q, sec_t_q, sec_u_q} == 16'h0000);
    assign at_one    = ({min_t_q, min_u_q, sec_t_q, sec_u_q} == 16'h0001);
    assign time_dec  = bcd_dec({min_t_q, min_u_q, sec_t_q, sec_u_q});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            min_t_q      <= 4'd0;
            min_u_q      <= 4'd0;
            sec_t_q      <= 4'd0;
            sec_u_q      <= 4'd0;
            beep_cnt_q   <= 4'd0;
            beep_q       <= 1'b0;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            clear_prev_q <= 1'b1;
            start_ev_q   <= 1'b0;
            stop_ev_q    <= 1'b0;
            clear_ev_q   <= 1'b0;
        end else begin
            start_prev_q <= bus.startn;
            stop_prev_q  <= bus.stopn;
            clear_prev_q <= bus.clearn;
            start_ev_q   <= start_prev_q & ~bus.startn;
            stop_ev_q    <= stop_prev_q  & ~bus.stopn;
            clear_ev_q   <= clear_prev_q & ~bus.clearn;

            case (state_q)
                S_IDLE: begin
                    if (clear_ev_q || stop_ev_q) begin
                        state_q <= S_IDLE;
                    end else if (start_ev_q) begin
                        if (bus.door_closed) begin
                            {min_t_q, min_u_q, sec_t_q, sec_u_q} <= {8'h00, QUICK_T, QUICK_U};
                            state_q <= S_COOKING;
                        end
                    end else if (key_ok) begin
                        {min_t_q, min_u_q, sec_t_q, sec_u_q} <= {12'h000, bus.key_digit};
                        state_q <= S_ENTRY;
                    end
                end

                S_ENTRY: begin
                    if (clear_ev_q) begin
                        {min_t_q, min_u_q, sec_t_q, sec_u_q} <= 16'h0000;
                        state_q <= S_IDLE;
                    end else if (stop_ev_q) begin
                        state_q <= S_ENTRY;
                    end else if (start_ev_q) begin
                        if (bus.door_closed) begin
                            if (time_zero)
                                {min_t_q, min_u_q, sec_t_q, sec_u_q} <= {8'h00, QUICK_T, QUICK_U};
                            state_q <= S_COOKING;
                        end
                    end else if (key_ok) begin
                        {min_t_q, min_u_q, sec_t_q, sec_u_q} <= {min_u_q, sec_t_q, sec_u_q, bus.key_digit};
                    end
                end

                S_COOKING: begin
                    if (!bus.door_closed || (stop_ev_q && !clear_ev_q)) begin
                        state_q <= S_PAUSED;
                    end else if (clear_ev_q) begin
                        {min_t_q, min_u_q, sec_t_q, sec_u_q} <= 16'h0000;
                        state_q <= S_IDLE;
                    end else if (!start_ev_q && bus.tick_1hz) begin
                        if (at_one) begin
                            {min_t_q, min_u_q, sec_t_q, sec_u_q} <= 16'h0000;
                            beep_q     <= 1'b1;
                            beep_cnt_q <= 4'd0;
                            state_q    <= S_DONE;
                        end else begin
                            {min_t_q, min_u_q, sec_t_q, sec_u_q} <= time_dec;
                        end
                    end
                end

                S_PAUSED: begin
                    if (clear_ev_q || stop_ev_q) begin
                        {min_t_q, min_u_q, sec_t_q, sec_u_q} <= 16'h0000;
                        state_q <= S_IDLE;
                    end else if (start_ev_q && bus.door_closed) begin
                        state_q <= S_COOKING;
                    end
                end

                S_DONE: begin
                    if (!bus.door_closed || clear_ev_q || stop_ev_q || start_ev_q) begin
                        beep_q     <= 1'b0;
                        beep_cnt_q <= 4'd0;
                        state_q    <= S_IDLE;
                    end else if (bus.tick_1hz) begin
                        if (beep_cnt_q == BEEP_END) begin
                            beep_q     <= 1'b0;
                            beep_cnt_q <= 4'd0;
                            state_q    <= S_IDLE;
                        end else begin
                            beep_cnt_q <= beep_cnt_q + 4'd1;
                        end
                    end
                end

                default: begin
                    {min_t_q, min_u_q, sec_t_q, sec_u_q} <= 16'h0000;
                    beep_q     <= 1'b0;
                    beep_cnt_q <= 4'd0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // Door switch gates the magnetron directly so opening cuts power before the FSM reacts.
    assign bus.mag_on  = (state_q == S_COOKING) && bus.door_closed;
    assign bus.beep    = beep_q;
    assign bus.min_t   = min_t_q;
    assign bus.min_u   = min_u_q;
    assign bus.sec_t   = sec_t_q;
    assign bus.sec_u   = sec_u_q;
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_microwave_sequencer.sv
// Directed bench for microwave_sequencer: entry, countdown, quick start, door interlock,
// button priority and asynchronous reset.
module tb_microwave_sequencer;

  logic clk;
  logic resetn;
  int   pass_cnt;
  int   total_cnt;

  microwave_sequencer_if bus();

  microwave_sequencer #(.QUICK_SEC(30), .BEEP_TICKS(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [15:0] disp;
  assign disp = {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    step(1);
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.tick_1hz = 1'b1;
      step(1);
      bus.tick_1hz = 1'b0;
    end
  endtask

  task automatic press_start();
    bus.startn = 1'b0; step(3); bus.startn = 1'b1; step(1);
  endtask

  task automatic press_stop();
    bus.stopn = 1'b0; step(3); bus.stopn = 1'b1; step(1);
  endtask

  task automatic press_clear();
    bus.clearn = 1'b0; step(3); bus.clearn = 1'b1; step(1);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(2);
    total_cnt++; if (bus.state_o !== 3'd0) $display("FAIL reset_state: got %0d expected 0", bus.state_o); else pass_cnt++;
    total_cnt++; if (disp !== 16'h0000) $display("FAIL reset_disp: got %h expected 0000", disp); else pass_cnt++;
    total_cnt++; if (bus.mag_on !== 1'b0) $display("FAIL reset_mag: got %b expected 0", bus.mag_on); else pass_cnt++;
    total_cnt++; if (bus.beep !== 1'b0) $display("FAIL reset_beep: got %b expected 0", bus.beep); else pass_cnt++;
    resetn = 1'b1;
    step(2);
  endtask

  task automatic test_entry_cook();
    key(4'd1); key(4'd3); key(4'd0);
    total_cnt++; if (bus.state_o !== 3'd1) $display("FAIL entry_state: got %0d expected 1", bus.state_o); else pass_cnt++;
    total_cnt++; if (disp !== 16'h0130) $display("FAIL entry_disp: got %h expected 0130", disp); else pass_cnt++;
    press_start();
    total_cnt++; if (bus.state_o !== 3'd2) $display("FAIL cook_state: got %0d expected 2", bus.state_o); else pass_cnt++;
    total_cnt++; if (bus.mag_on !== 1'b1) $display("FAIL cook_mag: got %b expected 1", bus.mag_on); else pass_cnt++;
    total_cnt++; if (disp !== 16'h0130) $display("FAIL cook_disp: got %h expected 0130", disp); else pass_cnt++;
    ticks(89);
    total_cnt++; if (disp !== 16'h0001) $display("FAIL cook_89: got %h expected 0001", disp); else pass_cnt++;
    ticks(1);
    total_cnt++; if (bus.state_o !== 3'd4) $display("FAIL done_state: got %0d expected 4", bus.state_o); else pass_cnt++;
    total_cnt++; if (disp !== 16'h0000) $display("FAIL done_disp: got %h expected 0000", disp); else pass_cnt++;
    total_cnt++; if (bus.mag_on !== 1'b0) $display("FAIL done_mag: got %b expected 0", bus.mag_on); else pass_cnt++;
    total_cnt++; if (bus.beep !== 1'b1) $display("FAIL done_beep: got %b expected 1", bus.beep); else pass_cnt++;
    ticks(2);
    total_cnt++; if (bus.beep !== 1'b1) $display("FAIL beep_hold: got %b expected 1", bus.beep); else pass_cnt++;
    ticks(1);
    total_cnt++; if (bus.state_o !== 3'd0) $display("FAIL beep_end_state: got %0d expected 0", bus.state_o); else pass_cnt++;
    total_cnt++; if (bus.beep !== 1'b0) $display("FAIL beep_end: got %b expected 0", bus.beep); else pass_cnt++;
  endtask

  task automatic test_quick_start();
    // Tick lands on the same clk the start event is acted on and must not count.
    bus.startn = 1'b0; step(1);
    bus.tick_1hz = 1'b1; step(1); bus.tick_1hz = 1'b0;
    step(1); bus.startn = 1'b1; step(1);
    total_cnt++; if (bus.state_o !== 3'd2) $display("FAIL quick_state: got %0d expected 2", bus.state_o); else pass_cnt++;
    total_cnt++; if (disp !== 16'h0030) $display("FAIL quick_disp: got %h expected 0030", disp); else pass_cnt++;
    ticks(20);
    total_cnt++; if (disp !== 16'h0010) $display("FAIL quick_10: got %h expected 0010", disp); else pass_cnt++;
    ticks(1);
    total_cnt++; if (disp !== 16'h0009) $display("FAIL borrow_sec: got %h expected 0009", disp); else pass_cnt++;
    press_clear();
    total_cnt++; if (bus.state_o !== 3'd0) $display("FAIL cook_clear_state: got %0d expected 0", bus.state_o); else pass_cnt++;
    total_cnt++; if (disp !== 16'h0000) $display("FAIL cook_clear_disp: got %h expected 0000", disp); else pass_cnt++;
    key(4'd1); key(4'd0); key(4'd0);
    press_start();
    ticks(1);
    total_cnt++; if (disp !== 16'h0059) $display("FAIL borrow_min: got %h expected 0059", disp); else pass_cnt++;
    press_clear();
  endtask

  task automatic test_long_seconds();
    key(4'd1); key(4'd9); key(4'd0);
    press_start();
    ticks(10);
    total_cnt++; if (disp !== 16'h0180) $display("FAIL sec90_10: got %h expected 0180", disp); else pass_cnt++;
    ticks(139);
    total_cnt++; if (disp !== 16'h0001) $display("FAIL sec90_149: got %h expected 0001", disp); else pass_cnt++;
    ticks(1);
    total_cnt++; if (bus.state_o !== 3'd4) $display("FAIL sec90_done: got %0d expected 4", bus.state_o); else pass_cnt++;
    press_clear();
    total_cnt++; if (bus.beep !== 1'b0) $display("FAIL silence_beep: got %b expected 0", bus.beep); else pass_cnt++;
    total_cnt++; if (bus.state_o !== 3'd0) $display("FAIL silence_state: got %0d expected 0", bus.state_o); else pass_cnt++;
  endtask

  task automatic test_shift();
    key(4'd5); key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    total_cnt++; if (disp !== 16'h1234) $display("FAIL shift_disp: got %h expected 1234", disp); else pass_cnt++;
    key(4'd12);
    total_cnt++; if (disp !== 16'h1234) $display("FAIL bad_key: got %h expected 1234", disp); else pass_cnt++;
    press_clear();
    total_cnt++; if (disp !== 16'h0000) $display("FAIL entry_clear_disp: got %h expected 0000", disp); else pass_cnt++;
    total_cnt++; if (bus.state_o !== 3'd0) $display("FAIL entry_clear_state: got %0d expected 0", bus.state_o); else pass_cnt++;
  endtask

  task automatic test_door();
    bus.door_closed = 1'b0;
    press_start();
    total_cnt++; if (bus.state_o !== 3'd0) $display("FAIL idle_door_start: got %0d expected 0", bus.state_o); else pass_cnt++;
    bus.door_closed = 1'b1;
    key(4'd4); key(4'd5);
    press_start();
    bus.door_closed = 1'b0;
    #1;
    total_cnt++; if (bus.mag_on !== 1'b0) $display("FAIL door_mag_now: got %b expected 0", bus.mag_on); else pass_cnt++;
    total_cnt++; if (bus.state_o !== 3'd2) $display("FAIL door_state_now: got %0d expected 2", bus.state_o); else pass_cnt++;
    step(1);
    total_cnt++; if (bus.state_o !== 3'd3) $display("FAIL door_paused: got %0d expected 3", bus.state_o); else pass_cnt++;
    ticks(5);
    total_cnt++; if (disp !== 16'h0045) $display("FAIL paused_hold: got %h expected 0045", disp); else pass_cnt++;
    press_start();
    total_cnt++; if (bus.state_o !== 3'd3) $display("FAIL paused_door_start: got %0d expected 3", bus.state_o); else pass_cnt++;
    bus.door_closed = 1'b1;
    step(1);
    total_cnt++; if (bus.mag_on !== 1'b0) $display("FAIL paused_mag: got %b expected 0", bus.mag_on); else pass_cnt++;
    press_start();
    total_cnt++; if (bus.state_o !== 3'd2) $display("FAIL resume_state: got %0d expected 2", bus.state_o); else pass_cnt++;
    total_cnt++; if (disp !== 16'h0045) $display("FAIL resume_disp: got %h expected 0045", disp); else pass_cnt++;
    ticks(1);
    total_cnt++; if (disp !== 16'h0044) $display("FAIL resume_tick: got %h expected 0044", disp); else pass_cnt++;
    press_clear();
  endtask

  task automatic test_back_to_back();
    key(4'd2); key(4'd0);
    press_start();
    bus.startn = 1'b0;
    bus.stopn  = 1'b0;
    step(3);
    total_cnt++; if (bus.state_o !== 3'd3) $display("FAIL stop_wins: got %0d expected 3", bus.state_o); else pass_cnt++;
    bus.stopn = 1'b1;
    step(5);
    total_cnt++; if (bus.state_o !== 3'd3) $display("FAIL held_start: got %0d expected 3", bus.state_o); else pass_cnt++;
    bus.startn = 1'b1;
    step(1);
    press_start();
    total_cnt++; if (bus.state_o !== 3'd2) $display("FAIL restart: got %0d expected 2", bus.state_o); else pass_cnt++;
    press_stop();
    press_stop();
    total_cnt++; if (bus.state_o !== 3'd0) $display("FAIL paused_stop_state: got %0d expected 0", bus.state_o); else pass_cnt++;
    total_cnt++; if (disp !== 16'h0000) $display("FAIL paused_stop_disp: got %h expected 0000", disp); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    key(4'd2); key(4'd1); key(4'd0);
    press_start();
    total_cnt++; if (disp !== 16'h0210) $display("FAIL pre_reset_disp: got %h expected 0210", disp); else pass_cnt++;
    total_cnt++; if (bus.mag_on !== 1'b1) $display("FAIL pre_reset_mag: got %b expected 1", bus.mag_on); else pass_cnt++;
    #2 resetn = 1'b0;
    #1;
    total_cnt++; if (bus.mag_on !== 1'b0) $display("FAIL areset_mag: got %b expected 0", bus.mag_on); else pass_cnt++;
    total_cnt++; if (disp !== 16'h0000) $display("FAIL areset_disp: got %h expected 0000", disp); else pass_cnt++;
    step(1);
    resetn = 1'b1;
    step(2);
    total_cnt++; if (bus.state_o !== 3'd0) $display("FAIL areset_state: got %0d expected 0", bus.state_o); else pass_cnt++;
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    resetn          = 1'b0;
    bus.tick_1hz    = 1'b0;
    bus.key_valid   = 1'b0;
    bus.key_digit   = 4'd0;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.clearn      = 1'b1;
    bus.door_closed = 1'b1;
    step(1);
    test_reset();
    test_entry_cook();
    test_quick_start();
    test_long_seconds();
    test_shift();
    test_door();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
